// File: rtl/wallace_pkg.sv
// Shared types and constants for the 8x8 Wallace-tree multiplier.
// WALLACE_PIPE_EN: when defined, a register stage sits after reduction level 2
// and the end-to-end latency becomes 2 cycles.
package wallace_pkg;

    localparam int MULT_W = 8;
    localparam int PROD_W = 17;

`ifdef WALLACE_PIPE_EN
    localparam int LATENCY = 2;
`else
    localparam int LATENCY = 1;
`endif

    typedef logic [MULT_W-1:0] operand_t;
    typedef logic [PROD_W-1:0] product_t;

endpackage

// File: rtl/csa_fa.sv
// 1-bit full adder used as the 3:2 compressor cell throughout the tree.
module csa_fa (
    input  logic a,
    input  logic b,
    input  logic c,
    output logic s,
    output logic co
);

    assign s  = a ^ b ^ c;
    assign co = (a & b) | (a & c) | (b & c);

endmodule

// File: rtl/wallace_mult8.sv
// Registered 8x8 unsigned multiplier: AND-array partial products, Wallace
// carry-save reduction (8 -> 6 -> 4 -> 3 -> 2 rows), 16-bit ripple CPA.
// P[16] is always zero; it exists only to match the Dadda variant's port.
// WALLACE_PIPE_EN: adds a register stage on the level-2 carry-save vectors
// and valid bit (latency 2 instead of 1).
module wallace_mult8 #(
    parameter int WIDTH = 8,
    parameter int PW    = 2*WIDTH+1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             out_valid,
    output logic [PW-1:0]    P
);
    import wallace_pkg::*;

    localparam int CW = 2*MULT_W;

    if (WIDTH != MULT_W || PW != PROD_W || LATENCY < 1) begin : g_bad_cfg
        $error("wallace_mult8 supports only WIDTH=8, PW=17");
    end

    operand_t a_op;
    operand_t b_op;
    assign a_op = A;
    assign b_op = B;

    logic [CW-1:0] pp_row [MULT_W];

    logic [CW-1:0] l1_x [2], l1_y [2], l1_z [2], l1_s [2], l1_co [2], l1_c [2];
    logic [CW-1:0] l2_x [2], l2_y [2], l2_z [2], l2_s [2], l2_co [2], l2_c [2];
    logic [CW-1:0] l3_s, l3_co, l3_c;
    logic [CW-1:0] l4_s, l4_co, l4_c;

    logic [CW-1:0] cs_d [4];
    logic [CW-1:0] cs [4];
    logic          stage_valid;

    logic [CW-1:0] sum;
    logic [CW:0]   rca_cy;

    product_t p_d, p_q;
    logic     out_valid_d, out_valid_q;

    // Shifted AND rows: row i holds A & B[i], weighted by 2^i.
    always_comb begin
        for (int i = 0; i < MULT_W; i++) begin
            pp_row[i] = {{MULT_W{1'b0}}, a_op & {MULT_W{b_op[i]}}} << i;
        end
    end

    // Level 1: rows {0,1,2} and {3,4,5} compress to two pairs; rows 6,7 pass.
    always_comb begin
        l1_x[0] = pp_row[0];
        l1_y[0] = pp_row[1];
        l1_z[0] = pp_row[2];
        l1_x[1] = pp_row[3];
        l1_y[1] = pp_row[4];
        l1_z[1] = pp_row[5];
        for (int k = 0; k < 2; k++) begin
            l1_c[k] = {l1_co[k][CW-2:0], 1'b0};
        end
    end

    for (genvar k = 0; k < 2; k++) begin : g_l1
        for (genvar bt = 0; bt < CW; bt++) begin : g_bit
            csa_fa u_fa (.a(l1_x[k][bt]), .b(l1_y[k][bt]), .c(l1_z[k][bt]),
                         .s(l1_s[k][bt]), .co(l1_co[k][bt]));
        end
    end

    // Level 2: six vectors regroup into two triples, leaving four.
    always_comb begin
        l2_x[0] = l1_s[0];
        l2_y[0] = l1_c[0];
        l2_z[0] = l1_s[1];
        l2_x[1] = l1_c[1];
        l2_y[1] = pp_row[6];
        l2_z[1] = pp_row[7];
        for (int k = 0; k < 2; k++) begin
            l2_c[k] = {l2_co[k][CW-2:0], 1'b0};
        end
        cs_d[0] = l2_s[0];
        cs_d[1] = l2_c[0];
        cs_d[2] = l2_s[1];
        cs_d[3] = l2_c[1];
    end

    for (genvar k = 0; k < 2; k++) begin : g_l2
        for (genvar bt = 0; bt < CW; bt++) begin : g_bit
            csa_fa u_fa (.a(l2_x[k][bt]), .b(l2_y[k][bt]), .c(l2_z[k][bt]),
                         .s(l2_s[k][bt]), .co(l2_co[k][bt]));
        end
    end

`ifdef WALLACE_PIPE_EN
    logic [CW-1:0] cs_q [4];
    logic          stage_valid_q;

    // Mid-tree register: holds the four carry-save rows and their valid bit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < 4; k++) begin
                cs_q[k] <= '0;
            end
            stage_valid_q <= 1'b0;
        end else begin
            for (int k = 0; k < 4; k++) begin
                cs_q[k] <= cs_d[k];
            end
            stage_valid_q <= in_valid;
        end
    end

    assign cs          = cs_q;
    assign stage_valid = stage_valid_q;
`else
    assign cs          = cs_d;
    assign stage_valid = in_valid;
`endif

    for (genvar bt = 0; bt < CW; bt++) begin : g_l34
        csa_fa u_fa3 (.a(cs[0][bt]), .b(cs[1][bt]), .c(cs[2][bt]),
                      .s(l3_s[bt]), .co(l3_co[bt]));
        csa_fa u_fa4 (.a(l3_s[bt]), .b(l3_c[bt]), .c(cs[3][bt]),
                      .s(l4_s[bt]), .co(l4_co[bt]));
        csa_fa u_rca (.a(l4_s[bt]), .b(l4_c[bt]), .c(rca_cy[bt]),
                      .s(sum[bt]), .co(rca_cy[bt+1]));
    end

    assign l3_c      = {l3_co[CW-2:0], 1'b0};
    assign l4_c      = {l4_co[CW-2:0], 1'b0};
    assign rca_cy[0] = 1'b0;

    // Carries out of column 15 are zero because the product fits in 16 bits.
    logic [6:0] unused_msb;
    assign unused_msb = {l1_co[0][CW-1], l1_co[1][CW-1], l2_co[0][CW-1],
                         l2_co[1][CW-1], l3_co[CW-1], l4_co[CW-1], rca_cy[CW]};

    // Output register loads only on a valid stage; otherwise P holds.
    always_comb begin
        p_d         = p_q;
        out_valid_d = stage_valid;
        if (stage_valid) begin
            p_d = {1'b0, sum};
        end
    end

    // Result register with asynchronous clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            p_q         <= '0;
            out_valid_q <= 1'b0;
        end else begin
            p_q         <= p_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign P         = p_q;
    assign out_valid = out_valid_q;

endmodule

// File: tb/tb_wallace_mult8.sv
// Self-checking bench for wallace_mult8: reference is A*B delayed by LATENCY.
module tb_wallace_mult8;
    import wallace_pkg::*;

    typedef struct packed {
        logic        v;
        logic [16:0] p;
    } hist_t;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic [7:0]  A;
    logic [7:0]  B;
    logic        out_valid;
    logic [16:0] P;

    int          n_checks;
    int          n_fail;
    hist_t       hist [$];
    logic        exp_v;
    logic [16:0] exp_p;
    logic [7:0]  s;
    logic [7:0]  la;
    logic [7:0]  lb;

    wallace_mult8 #(.WIDTH(8), .PW(17)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (in_valid),
        .A        (A),
        .B        (B),
        .out_valid(out_valid),
        .P        (P)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        hist.delete();
        exp_v = 1'b0;
        exp_p = '0;
    endtask

    // One clock: drive inputs, advance the reference delay line, compare.
    task automatic cycle(input logic v, input logic [7:0] a, input logic [7:0] b);
        logic [16:0] prod;
        in_valid = v;
        A        = a;
        B        = b;
        prod     = {9'b0, a} * {9'b0, b};
        @(posedge clk);
        hist.push_back(hist_t'{v, prod});
        if (hist.size() > LATENCY) void'(hist.pop_front());
        if (hist.size() == LATENCY) begin
            exp_v = hist[0].v;
            if (exp_v) exp_p = hist[0].p;
        end else begin
            exp_v = 1'b0;
        end
        #1;
        check_eq("out_valid", {31'b0, out_valid}, {31'b0, exp_v});
        check_eq("P", {15'b0, P}, {15'b0, exp_p});
    endtask

    task automatic run_pair(input string tag, input logic [7:0] a, input logic [7:0] b,
                            input logic [16:0] expect_p);
        cycle(1'b1, a, b);
        repeat (LATENCY - 1) cycle(1'b0, 8'h00, 8'h00);
        check_eq(tag, {15'b0, P}, {15'b0, expect_p});
        check_eq("P16_zero", {31'b0, P[16]}, 32'd0);
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        model_reset();
        rst_n    = 1'b0;
        in_valid = 1'b1;
        A        = 8'hFF;
        B        = 8'hFF;

        repeat (3) begin
            @(posedge clk);
            #1;
            check_eq("rst_P", {15'b0, P}, 32'd0);
            check_eq("rst_valid", {31'b0, out_valid}, 32'd0);
        end
        @(negedge clk);
        rst_n = 1'b1;

        run_pair("c_zero", 8'h00, 8'hAB, 17'h00000);
        run_pair("c_one",  8'h01, 8'hAB, 17'h000AB);
        run_pair("c_max",  8'hFF, 8'hFF, 17'h0FE01);
        run_pair("c_msb",  8'h80, 8'h80, 17'h04000);
        run_pair("lfsr01", 8'h0E, 8'hF1, 17'h00D2E);
        run_pair("lfsrFF", 8'hF0, 8'h0F, 17'h00E10);

        s = 8'h01;
        repeat (255) begin
            la = {s[7:4], ~s[3:0]};
            lb = {~s[7:4], s[3:0]};
            cycle(1'b1, la, lb);
            s = {s[6:0], s[7] ^ s[5] ^ s[4] ^ s[3]};
        end

        cycle(1'b1, 8'h37, 8'h5A);
        cycle(1'b0, 8'hC3, 8'h99);
        cycle(1'b0, 8'h11, 8'h22);
        cycle(1'b1, 8'h9D, 8'h4E);
        repeat (LATENCY) cycle(1'b0, 8'hEE, 8'hDD);

        repeat (400) cycle(1'($urandom_range(0, 1)), 8'($urandom), 8'($urandom));

        cycle(1'b1, 8'hFF, 8'hFF);
        cycle(1'b1, 8'hFE, 8'hFD);
        #2;
        rst_n = 1'b0;
        #1;
        check_eq("async_P", {15'b0, P}, 32'd0);
        check_eq("async_valid", {31'b0, out_valid}, 32'd0);
        #1;
        rst_n = 1'b1;
        model_reset();
        cycle(1'b0, 8'h00, 8'h00);
        check_eq("post_rst_valid", {31'b0, out_valid}, 32'd0);

        for (int k = 0; k < 256; k++) cycle(1'b1, 8'(k), 8'(k));

        for (int a = 0; a < 256; a++) begin
            for (int b = 0; b < 256; b++) begin
                cycle(1'b1, 8'(a), 8'(b));
            end
        end
        repeat (LATENCY) cycle(1'b0, 8'h00, 8'h00);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
